// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER) + 1;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  // Magnitude of a two's complement word; |INT_MIN| comes out as unsigned 0x80000000.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract the divisor.
module div_step (
  input  logic [31:0] r,
  input  logic [31:0] q,
  input  logic [31:0] d,
  output logic [31:0] r_next,
  output logic [31:0] q_next
);

  logic [32:0] r_sh;
  logic [32:0] diff;

  // R < d <= 2^31, so the shifted remainder stays below 2^32 and diff[32] is a true sign.
  assign r_sh   = {r, q[31]};
  assign diff   = r_sh - {1'b0, d};
  assign r_next = diff[32] ? r_sh[31:0] : diff[31:0];
  assign q_next = {q[30:0], ~diff[32]};

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply (radix-2 Booth) / divide (restoring), one bit per clock.
module multdiv_seq
  import multdiv_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic signed [31:0] a_reg;
  logic signed [31:0] p_reg;
  logic [31:0]        q_reg;
  logic               qm1;
  logic [31:0]        r_reg;
  logic [31:0]        bmag;
  logic               neg_q;
  logic               div_zero;
  logic               div_ovf;

  logic signed [32:0] booth_sum;
  logic [32:0]        hi_bits;
  logic               mult_ovf;
  logic [31:0]        r_nxt;
  logic [31:0]        q_nxt;
  logic [31:0]        quot;

  // 33-bit Booth adder so P +/- A never loses its sign before the shift.
  always_comb begin
    booth_sum = {p_reg[31], p_reg};
    case ({q_reg[0], qm1})
      2'b01:   booth_sum = {p_reg[31], p_reg} + {a_reg[31], a_reg};
      2'b10:   booth_sum = {p_reg[31], p_reg} - {a_reg[31], a_reg};
      default: booth_sum = {p_reg[31], p_reg};
    endcase
  end

  assign hi_bits  = {p_reg, q_reg[31]};
  assign mult_ovf = !((&hi_bits) || !(|hi_bits));
  assign quot     = neg_q ? (32'd0 - q_reg) : q_reg;

  div_step u_div_step (
    .r      (r_reg),
    .q      (q_reg),
    .d      (bmag),
    .r_next (r_nxt),
    .q_next (q_nxt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      a_reg          <= '0;
      p_reg          <= '0;
      q_reg          <= '0;
      qm1            <= 1'b0;
      r_reg          <= '0;
      bmag           <= '0;
      neg_q          <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      // A new request always wins, aborting whatever was in flight.
      cnt            <= '0;
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= MULT;
        a_reg <= data_operandA;
        p_reg <= '0;
        q_reg <= data_operandB;
        qm1   <= 1'b0;
      end else begin
        state    <= DIV;
        r_reg    <= '0;
        q_reg    <= mag32(data_operandA);
        bmag     <= mag32(data_operandB);
        neg_q    <= data_operandA[31] ^ data_operandB[31];
        div_zero <= (data_operandB == '0);
        div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
      end
    end else begin
      case (state)
        IDLE: data_resultRDY <= 1'b0;
        MULT: begin
          if (cnt == CNT_W'(ITER)) begin
            state          <= DONE;
            data_result    <= q_reg;
            data_exception <= mult_ovf;
            data_resultRDY <= 1'b1;
          end else begin
            p_reg <= booth_sum[32:1];
            q_reg <= {booth_sum[0], q_reg[31:1]};
            qm1   <= q_reg[0];
            cnt   <= cnt + CNT_W'(1);
          end
        end
        DIV: begin
          if (cnt == CNT_W'(ITER)) begin
            state          <= DONE;
            data_result    <= div_zero ? 32'd0 : (div_ovf ? INT_MIN : quot);
            data_exception <= div_zero || div_ovf;
            data_resultRDY <= 1'b1;
          end else begin
            r_reg <= r_nxt;
            q_reg <= q_nxt;
            cnt   <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
// Bench for multdiv_seq: arithmetic reference model with latency scoreboard plus directed literal cases.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;

  multdiv_seq dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result as plain signed arithmetic.
  function automatic void ref_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
    longint p;
    int     qv;
    if (mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      qv = $signed(a) / $signed(b);
      r  = qv;
      e  = 1'b0;
    end
  endfunction

  // Scoreboard: latest request replaces any pending one; it is due 33 edges later.
  int          edge_no = 0;
  int          due     = 0;
  bit          pending = 0;
  logic [31:0] p_res   = '0;
  logic        p_exc   = 1'b0;
  logic        m_rdy   = 1'b0;
  logic [31:0] m_res   = '0;
  logic        m_exc   = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pending = 0;
      m_rdy   = 1'b0;
      m_res   = '0;
      m_exc   = 1'b0;
    end else begin
      edge_no++;
      m_rdy = 1'b0;
      if (ctrl_MULT || ctrl_DIV) begin
        ref_op(ctrl_MULT, data_operandA, data_operandB, p_res, p_exc);
        pending = 1;
        due     = edge_no + 33;
      end else if (pending && edge_no == due) begin
        m_rdy   = 1'b1;
        m_res   = p_res;
        m_exc   = p_exc;
        pending = 0;
      end
    end
  end

  always @(negedge clock) begin
    chk("rdy", {31'b0, data_resultRDY}, {31'b0, m_rdy});
    chk("result", data_result, m_res);
    chk("exception", {31'b0, data_exception}, {31'b0, m_exc});
  end

  task automatic run_op(input bit imm, input bit mul, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee, input string nm);
    int n;
    if (!imm) @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mul;
    ctrl_DIV      = !mul;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    n = 0;
    while (!data_resultRDY && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd33);
    chk({nm, "_result"}, data_result, er);
    chk({nm, "_exc"}, {31'b0, data_exception}, {31'b0, ee});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int sel;
    int gap;
    #1 reset = 1'b1;
    #1;
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc", {31'b0, data_exception}, 32'd0);
    chk("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_op(0, 1, 32'd7, -32'sd6, 32'hFFFF_FFD6, 1'b0, "mul_7x-6");
    run_op(1, 0, -32'sd100, 32'd7, 32'hFFFF_FFF2, 1'b0, "div_-100/7");
    run_op(0, 0, 32'd100, -32'sd7, 32'hFFFF_FFF2, 1'b0, "div_100/-7");
    run_op(0, 1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf");
    run_op(0, 1, 32'h0000_8000, -32'sh10000, 32'h8000_0000, 1'b0, "mul_intmin");
    run_op(0, 0, 32'd5, 32'd0, 32'd0, 1'b1, "div_by_zero");
    run_op(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_intmin_neg1");

    // Abort a divide with a multiply ten edges later.
    @(negedge clock);
    data_operandA = 32'd9;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (8) @(negedge clock);
    run_op(0, 1, 32'd3, 32'd4, 32'd12, 1'b0, "abort_restart");

    // Reset partway through a multiply.
    @(negedge clock);
    data_operandA = 32'd1234;
    data_operandB = 32'd5678;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (20) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midreset_result", data_result, 32'd0);
    chk("midreset_rdy", {31'b0, data_resultRDY}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    run_op(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, "mul_-1x-1");

    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      data_operandA = pick();
      data_operandB = pick();
      sel           = $urandom_range(0, 9);
      ctrl_MULT     = (sel < 5) || (sel == 9);
      ctrl_DIV      = (sel >= 5);
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      gap = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 27) : $urandom_range(28, 36);
      repeat (gap) @(negedge clock);
    end
    repeat (40) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
